// File: rtl/rr_arb16.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb16
// Brief    : 16-way round-robin arbiter, registered index + one-hot grant.
// Revision : 1.0  initial release
// ============================================================================
module rr_arb16 #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        done,
    output logic        gnt_valid,
    output logic [3:0]  gnt_idx,
    output logic [15:0] gnt,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] c_hold    = 8'(HOLD_MAX);
    localparam logic [7:0] c_cnt_max = 8'hFF;

    state_t      r_state, w_state_n;
    logic [3:0]  r_ptr, w_ptr_n;
    logic [3:0]  r_idx, w_idx_n;
    logic [7:0]  r_cnt, w_cnt_n;
    logic        r_timeout, w_timeout_n;

    logic        w_hold_hit;
    logic        w_release;
    logic [3:0]  w_next_ptr;
    logic [15:0] w_masked;

    // First set bit of v at or after position p, wrapping modulo 16.
    function automatic logic [3:0] rr_pick(input logic [15:0] v, input logic [3:0] p);
        logic [31:0] dbl;
        logic [3:0]  k;
        dbl = {v, v} >> p;
        k   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (dbl[i]) k = 4'(i);
        end
        return p + k;
    endfunction

    assign w_hold_hit = (HOLD_MAX != 0) && (r_cnt == c_hold);
    assign w_release  = done || !req[r_idx] || w_hold_hit;
    assign w_next_ptr = r_idx + 4'd1;
    assign w_masked   = req & ~(16'd1 << r_idx);

    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_idx_n     = r_idx;
        w_cnt_n     = r_cnt;
        w_timeout_n = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && (req != 16'd0)) begin
                    w_idx_n   = rr_pick(req, r_ptr);
                    w_cnt_n   = 8'd1;
                    w_state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_n     = w_next_ptr;
                    // Pulse only when the hold limit alone forced the release.
                    w_timeout_n = w_hold_hit && !done && req[r_idx];
                    if (en && (w_masked != 16'd0)) begin
                        w_idx_n = rr_pick(w_masked, w_next_ptr);
                        w_cnt_n = 8'd1;
                    end else if (en && req[r_idx]) begin
                        w_cnt_n = 8'd1;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end else if (r_cnt != c_cnt_max) begin
                    w_cnt_n = r_cnt + 8'd1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 4'd0;
            r_idx     <= 4'd0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ptr     <= w_ptr_n;
            r_idx     <= w_idx_n;
            r_cnt     <= w_cnt_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign gnt_valid = (r_state == S_GRANT);
    assign busy      = gnt_valid;
    assign gnt_idx   = r_idx;
    assign gnt       = gnt_valid ? (16'd1 << r_idx) : 16'd0;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb16
// Brief    : Directed self-checking bench for rr_arb16 (HOLD_MAX = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_arb16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic        gnt_valid;
    logic [3:0]  gnt_idx;
    logic [15:0] gnt;
    logic        timeout;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rr_arb16 #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic v, input logic [3:0] idx,
                             input logic [15:0] g, input logic to);
        check({tag, ".valid"},   32'(gnt_valid), 32'(v));
        check({tag, ".busy"},    32'(busy),      32'(v));
        check({tag, ".idx"},     32'(gnt_idx),   32'(idx));
        check({tag, ".gnt"},     32'(gnt),       32'(g));
        check({tag, ".timeout"}, 32'(timeout),   32'(to));
    endtask

    logic [3:0] seq_rot [6]  = '{4'd3, 4'd5, 4'd10, 4'd3, 4'd5, 4'd10};
    logic [3:0] seq_to_i [8] = '{4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15};
    logic       seq_to_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = 16'h0000;
        done = 1'b0;

        // Reset held two cycles
        step();
        step();
        check_all("reset", 1'b0, 4'd0, 16'h0000, 1'b0);

        // No requests: nothing granted
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("idle", 1'b0, 4'd0, 16'h0000, 1'b0);
        end

        // Single requester, done every third cycle: continuous re-grant
        req = 16'h0001;
        step();
        check_all("single.first", 1'b1, 4'd0, 16'h0001, 1'b0);
        for (int i = 0; i < 9; i++) begin
            done = (i % 3 == 2);
            step();
            check_all("single.hold", 1'b1, 4'd0, 16'h0001, 1'b0);
        end

        // Rotation among bits 3,5,10 with done each grant cycle (ptr is 1 here)
        req  = 16'h0428;
        done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_all("rotate", 1'b1, seq_rot[i], 16'd1 << seq_rot[i], 1'b0);
        end
        done = 1'b0;

        // Forced release after 4 cycles, 15 -> 0 wrap; ptr parked at 15 via idx 14
        rst = 1'b1;
        req = 16'h0000;
        step();
        check_all("reset2", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst = 1'b0;
        req = 16'h4000;
        step();
        check_all("to.pre", 1'b1, 4'd14, 16'h4000, 1'b0);
        req = 16'h8001;
        step();
        check_all("to.start", 1'b1, 4'd15, 16'h8000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_all("to.seq", 1'b1, seq_to_i[i], 16'd1 << seq_to_i[i], seq_to_t[i]);
        end

        // en=0 blocks re-arbitration on release; ptr advances to 8
        rst = 1'b1;
        req = 16'h0000;
        step();
        rst = 1'b0;
        req = 16'h0080;
        step();
        check_all("en.g7", 1'b1, 4'd7, 16'h0080, 1'b0);
        en   = 1'b0;
        done = 1'b1;
        req  = 16'h0180;
        step();
        check_all("en.drop", 1'b0, 4'd7, 16'h0000, 1'b0);
        done = 1'b0;
        en   = 1'b1;
        step();
        check_all("en.g8", 1'b1, 4'd8, 16'h0100, 1'b0);
        en = 1'b0;
        step();
        check_all("en.keep", 1'b1, 4'd8, 16'h0100, 1'b0);
        en = 1'b1;

        // Reset mid-grant (idx 6, cnt 3), then ptr restarts at 0
        rst = 1'b1;
        req = 16'h0000;
        step();
        rst = 1'b0;
        req = 16'h0040;
        step();
        step();
        step();
        check_all("rst.mid.pre", 1'b1, 4'd6, 16'h0040, 1'b0);
        rst = 1'b1;
        step();
        check_all("rst.mid", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst = 1'b0;
        req = 16'h0041;
        step();
        check_all("rst.after", 1'b1, 4'd0, 16'h0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
